// File: rtl/core_run_ctrl_if.sv
// Run-controller bus: launch/abort controls, core status inputs and run results.
// Config macro RUN_CTRL_SIG_EN adds the write-back signature signals.
interface core_run_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // Controls and core status into the controller
    logic             start;
    logic             abort;
    logic             retire;
    logic             halt_valid;
    logic [XLEN-1:0]  halt_code;
    // Registered results out of the controller
    logic             core_reset;
    logic             running;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;
`ifdef RUN_CTRL_SIG_EN
    logic             wb_valid;
    logic [XLEN-1:0]  wb_data;
    logic [XLEN-1:0]  signature;

    modport master (
        output start, abort, retire, halt_valid, halt_code, wb_valid, wb_data,
        input  core_reset, running, done, pass, timeout, cycle_count, instret_count, signature
    );
    modport slave (
        input  start, abort, retire, halt_valid, halt_code, wb_valid, wb_data,
        output core_reset, running, done, pass, timeout, cycle_count, instret_count, signature
    );
`else
    modport master (
        output start, abort, retire, halt_valid, halt_code,
        input  core_reset, running, done, pass, timeout, cycle_count, instret_count
    );
    modport slave (
        input  start, abort, retire, halt_valid, halt_code,
        output core_reset, running, done, pass, timeout, cycle_count, instret_count
    );
`endif
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences the datapath reset, bounds the run by a cycle
// budget and reports pass/fail/timeout with cycle and retire counts.
// Optional write-back signature enabled by defining RUN_CTRL_SIG_EN.
module core_run_ctrl #(
    parameter int          XLEN         = 32,
    parameter int          CNT_W        = 32,
    parameter int          RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 30,
    parameter logic [XLEN-1:0] PASS_CODE = '0
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    core_run_ctrl_if.slave bus
);
    localparam int               HOLD_W   = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic              core_reset_q, running_q, done_q, pass_q, timeout_q;
    logic              budget_hit;
`ifdef RUN_CTRL_SIG_EN
    logic [XLEN-1:0]   sig_q, sig_d;
`endif

    // Next counter values for a RUN cycle; budget expires when the count lands on MAX
    always_comb begin
        cyc_d      = cyc_q + 1'b1;
        ret_d      = ret_q + CNT_W'(bus.retire);
        budget_hit = (cyc_d == MAX_CNT);
`ifdef RUN_CTRL_SIG_EN
        sig_d      = bus.wb_valid ? ({sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ bus.wb_data) : sig_q;
`endif
    end

    // Run sequencer: all outputs are registered alongside the state
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            cyc_q        <= '0;
            ret_q        <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef RUN_CTRL_SIG_EN
            sig_q        <= '0;
`endif
        end else begin
            case (state_q)
                // Launch from idle or after a finished run; results are wiped on this edge
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q      <= S_HOLD;
                        hold_q       <= '0;
                        cyc_q        <= '0;
                        ret_q        <= '0;
                        core_reset_q <= 1'b1;
                        running_q    <= 1'b0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
`ifdef RUN_CTRL_SIG_EN
                        sig_q        <= '0;
`endif
                    end
                end
                // Keep the core in reset; start is ignored, abort drops back to idle
                S_HOLD: begin
                    if (bus.abort) begin
                        state_q      <= S_IDLE;
                        core_reset_q <= 1'b1;
                    end else if (hold_q == HOLD_END) begin
                        state_q      <= S_RUN;
                        core_reset_q <= 1'b0;
                        running_q    <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                // The terminating cycle is still a RUN cycle, so it is always counted
                S_RUN: begin
                    cyc_q <= cyc_d;
                    ret_q <= ret_d;
`ifdef RUN_CTRL_SIG_EN
                    sig_q <= sig_d;
`endif
                    if (bus.abort) begin
                        state_q      <= S_IDLE;
                        core_reset_q <= 1'b1;
                        running_q    <= 1'b0;
                    end else if (bus.halt_valid) begin
                        state_q      <= S_DONE;
                        core_reset_q <= 1'b1;
                        running_q    <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= (bus.halt_code == PASS_CODE);
                        timeout_q    <= 1'b0;
                    end else if (budget_hit) begin
                        state_q      <= S_DONE;
                        core_reset_q <= 1'b1;
                        running_q    <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_q <= 1'b1;
                    running_q    <= 1'b0;
                    done_q       <= 1'b0;
                    pass_q       <= 1'b0;
                    timeout_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_reset    = core_reset_q;
    assign bus.running       = running_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.cycle_count   = cyc_q;
    assign bus.instret_count = ret_q;
`ifdef RUN_CTRL_SIG_EN
    assign bus.signature     = sig_q;
`endif
endmodule
